// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal/vertical scan counters plus registered sync,
// blanking and strobe decode, all aligned with the counters they describe.
module vga_timing_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       pixel_clk,
  input  logic       reset,
  output logic [9:0] X_pix,
  output logic [9:0] Y_pix,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_von_nxt;
  logic       w_le_nxt;
  logic       w_fs_nxt;

  // Next scan position: X wraps at end of line, Y advances on that wrap.
  always_comb begin
    w_x_nxt = X_pix + 10'd1;
    w_y_nxt = Y_pix;
    if (X_pix == H_LAST) begin
      w_x_nxt = 10'd0;
      if (Y_pix == V_LAST) begin
        w_y_nxt = 10'd0;
      end else begin
        w_y_nxt = Y_pix + 10'd1;
      end
    end else begin
      w_y_nxt = Y_pix;
    end
  end

  // Decode from the next position so the registered flags match the registered counters.
  always_comb begin
    w_hs_nxt  = ((w_x_nxt >= HS_START) && (w_x_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vs_nxt  = ((w_y_nxt >= VS_START) && (w_y_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_von_nxt = (w_x_nxt < H_VIS_C) && (w_y_nxt < V_VIS_C);
    w_le_nxt  = (w_x_nxt == H_LAST);
    w_fs_nxt  = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
  end

  // Counter and output registers; reset parks on the last pixel so release lands on (0,0).
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      X_pix       <= H_LAST;
      Y_pix       <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      X_pix       <= w_x_nxt;
      Y_pix       <= w_y_nxt;
      hsync       <= w_hs_nxt;
      vsync       <= w_vs_nxt;
      video_on    <= w_von_nxt;
      line_end    <= w_le_nxt;
      frame_start <= w_fs_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a standard 640x480 instance and a small active-high-sync
// instance (32x20) so full-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  localparam int AHT = 800, AVT = 525;
  localparam int BHV = 16, BHF = 4, BHS = 6, BHB = 6;
  localparam int BVV = 12, BVF = 2, BVS = 2, BVB = 4;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  logic       rst_a, rst_b;
  logic [9:0] xa, ya, xb, yb;
  logic       hsa, vsa, vona, lea, fsa;
  logic       hsb, vsb, vonb, leb, fsb;

  vga_timing_gen dut_a (
    .pixel_clk(pixel_clk), .reset(rst_a), .X_pix(xa), .Y_pix(ya), .hsync(hsa),
    .vsync(vsa), .video_on(vona), .line_end(lea), .frame_start(fsa)
  );

  vga_timing_gen #(
    .H_VIS(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_VIS(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b1)
  ) dut_b (
    .pixel_clk(pixel_clk), .reset(rst_b), .X_pix(xb), .Y_pix(yb), .hsync(hsb),
    .vsync(vsb), .video_on(vonb), .line_end(leb), .frame_start(fsb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {hsync, vsync, video_on, line_end, frame_start} at a raster position.
  function automatic logic [4:0] model_out(int x, int y, bit r, int hv, int hf, int hs, int ht,
                                           int vv, int vf, int vs, logic pol);
    logic h, v;
    if (r) return {~pol, ~pol, 3'b000};
    h = (x >= hv + hf && x < hv + hf + hs) ? pol : ~pol;
    v = (y >= vv + vf && y < vv + vf + vs) ? pol : ~pol;
    return {h, v, (x < hv && y < vv), (x == ht - 1), (x == 0 && y == 0)};
  endfunction

  int ma_x, ma_y, mb_x, mb_y;
  bit ma_rst, mb_rst;
  bit ma_valid = 1'b0, mb_valid = 1'b0;

  // Position model for instance A.
  always @(posedge pixel_clk) begin
    if (rst_a) begin
      ma_x <= AHT - 1; ma_y <= AVT - 1; ma_rst <= 1'b1; ma_valid <= 1'b1;
    end else if (ma_valid) begin
      ma_rst <= 1'b0;
      ma_x   <= (ma_x + 1) % AHT;
      if (ma_x == AHT - 1) ma_y <= (ma_y + 1) % AVT;
    end
  end

  // Position model for instance B.
  always @(posedge pixel_clk) begin
    if (rst_b) begin
      mb_x <= BHT - 1; mb_y <= BVT - 1; mb_rst <= 1'b1; mb_valid <= 1'b1;
    end else if (mb_valid) begin
      mb_rst <= 1'b0;
      mb_x   <= (mb_x + 1) % BHT;
      if (mb_x == BHT - 1) mb_y <= (mb_y + 1) % BVT;
    end
  end

  logic [4:0] ea, eb;

  // Every-cycle comparison of both instances against the model.
  always @(negedge pixel_clk) begin
    if (ma_valid) begin
      ea = model_out(ma_x, ma_y, ma_rst, 640, 16, 96, AHT, 480, 10, 2, 1'b0);
      chk($sformatf("A.X(%0d,%0d)", ma_x, ma_y), 32'(xa), ma_x);
      chk($sformatf("A.Y(%0d,%0d)", ma_x, ma_y), 32'(ya), ma_y);
      chk($sformatf("A.hsync(%0d,%0d)", ma_x, ma_y), 32'(hsa), 32'(ea[4]));
      chk($sformatf("A.vsync(%0d,%0d)", ma_x, ma_y), 32'(vsa), 32'(ea[3]));
      chk($sformatf("A.video_on(%0d,%0d)", ma_x, ma_y), 32'(vona), 32'(ea[2]));
      chk($sformatf("A.line_end(%0d,%0d)", ma_x, ma_y), 32'(lea), 32'(ea[1]));
      chk($sformatf("A.frame_start(%0d,%0d)", ma_x, ma_y), 32'(fsa), 32'(ea[0]));
    end
    if (mb_valid) begin
      eb = model_out(mb_x, mb_y, mb_rst, BHV, BHF, BHS, BHT, BVV, BVF, BVS, 1'b1);
      chk($sformatf("B.X(%0d,%0d)", mb_x, mb_y), 32'(xb), mb_x);
      chk($sformatf("B.Y(%0d,%0d)", mb_x, mb_y), 32'(yb), mb_y);
      chk($sformatf("B.hsync(%0d,%0d)", mb_x, mb_y), 32'(hsb), 32'(eb[4]));
      chk($sformatf("B.vsync(%0d,%0d)", mb_x, mb_y), 32'(vsb), 32'(eb[3]));
      chk($sformatf("B.video_on(%0d,%0d)", mb_x, mb_y), 32'(vonb), 32'(eb[2]));
      chk($sformatf("B.line_end(%0d,%0d)", mb_x, mb_y), 32'(leb), 32'(eb[1]));
      chk($sformatf("B.frame_start(%0d,%0d)", mb_x, mb_y), 32'(fsb), 32'(eb[0]));
    end
  end

  int a_hs_low = 0, a_le = 0;
  int b_von = 0, b_le = 0, b_vs = 0, b_fs_prev = -1;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("A.reset_X", 32'(xa), 799);   chk("A.reset_Y", 32'(ya), 524);
    chk("A.reset_hs", 32'(hsa), 1);   chk("A.reset_vs", 32'(vsa), 1);
    chk("A.reset_von", 32'(vona), 0); chk("A.reset_le", 32'(lea), 0);
    chk("A.reset_fs", 32'(fsa), 0);
    chk("B.reset_X", 32'(xb), 31);    chk("B.reset_Y", 32'(yb), 19);
    chk("B.reset_hs", 32'(hsb), 0);   chk("B.reset_vs", 32'(vsb), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge pixel_clk);

    for (int c = 0; c < 1610; c++) begin
      if (c < 800 && hsa == 1'b0) a_hs_low++;
      if (c < 800 && lea == 1'b1) a_le++;
      if (c < 640 && vonb == 1'b1) b_von++;
      if (c < 640 && leb == 1'b1) b_le++;
      if (c < 640 && vsb == 1'b1) b_vs++;
      if (fsb == 1'b1 && c < 1290) begin
        if (b_fs_prev >= 0) chk("B.fs_period", c - b_fs_prev, 640);
        b_fs_prev = c;
      end
      case (c)
        0: begin
          chk("A.first_X", 32'(xa), 0);  chk("A.first_Y", 32'(ya), 0);
          chk("A.first_von", 32'(vona), 1); chk("A.first_fs", 32'(fsa), 1);
          chk("A.first_hs", 32'(hsa), 1); chk("A.first_vs", 32'(vsa), 1);
          chk("B.first_fs", 32'(fsb), 1); chk("B.first_hs", 32'(hsb), 0);
        end
        367:  chk("B.von(15,11)", 32'(vonb), 1);
        368:  chk("B.von(16,11)", 32'(vonb), 0);
        384:  chk("B.von(0,12)", 32'(vonb), 0);
        639:  begin chk("B.wrap_X", 32'(xb), 31); chk("B.wrap_Y", 32'(yb), 19); end
        640:  begin chk("B.wrapped_X", 32'(xb), 0); chk("B.wrapped_Y", 32'(yb), 0);
                    chk("B.wrapped_fs", 32'(fsb), 1); end
        655:  chk("A.hs(655)", 32'(hsa), 1);
        656:  chk("A.hs(656)", 32'(hsa), 0);
        751:  chk("A.hs(751)", 32'(hsa), 0);
        752:  chk("A.hs(752)", 32'(hsa), 1);
        799:  begin chk("A.le_X", 32'(xa), 799); chk("A.le", 32'(lea), 1); end
        800:  begin chk("A.line2_X", 32'(xa), 0); chk("A.line2_Y", 32'(ya), 1); end
        1300: begin chk("B.pre_rst_X", 32'(xb), 20); chk("B.pre_rst_hs", 32'(hsb), 1);
                    rst_b = 1'b1; end
        1301: begin chk("B.mid_rst_X", 32'(xb), 31); chk("B.mid_rst_Y", 32'(yb), 19);
                    chk("B.mid_rst_hs", 32'(hsb), 0); chk("B.mid_rst_fs", 32'(fsb), 0);
                    rst_b = 1'b0; end
        1302: begin chk("B.post_rst_X", 32'(xb), 0); chk("B.post_rst_fs", 32'(fsb), 1); end
        1500: begin chk("A.pre_rst_X", 32'(xa), 700); chk("A.pre_rst_Y", 32'(ya), 1);
                    chk("A.pre_rst_hs", 32'(hsa), 0); rst_a = 1'b1; end
        1501: begin chk("A.mid_rst_X", 32'(xa), 799); chk("A.mid_rst_Y", 32'(ya), 524);
                    chk("A.mid_rst_hs", 32'(hsa), 1); chk("A.mid_rst_von", 32'(vona), 0);
                    chk("A.mid_rst_le", 32'(lea), 0); chk("A.mid_rst_fs", 32'(fsa), 0);
                    rst_a = 1'b0; end
        1502: begin chk("A.post_rst_X", 32'(xa), 0); chk("A.post_rst_Y", 32'(ya), 0);
                    chk("A.post_rst_fs", 32'(fsa), 1); chk("A.post_rst_von", 32'(vona), 1); end
        default: ;
      endcase
      @(negedge pixel_clk);
    end

    chk("A.hsync_low_clks", a_hs_low, 96);
    chk("A.line_end_count", a_le, 1);
    chk("B.video_on_clks", b_von, BHV * BVV);
    chk("B.line_end_count", b_le, BVT);
    chk("B.vsync_active_clks", b_vs, BVS * BHT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
